// File: rtl/crc_pkg.sv
// Shared CRC definitions for the serial CRC generator and checker:
// FSM state encoding, CRC-8 defaults and the single-bit LFSR step.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  localparam int         CRC_MAX_W = 32;

  // Bits above `width` are masked off so one routine serves any CRC width.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] lfsr,
    input logic                 in_bit,
    input logic [CRC_MAX_W-1:0] poly,
    input int                   width
  );
    logic [CRC_MAX_W-1:0] top;
    logic [CRC_MAX_W-1:0] mask;
    logic                 fb;
    top  = lfsr >> (width - 1);
    fb   = top[0] ^ in_bit;
    mask = (width >= CRC_MAX_W) ? '1 : ((CRC_MAX_W'(1) << width) - CRC_MAX_W'(1));
    return ((lfsr << 1) ^ (fb ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/crc_lfsr_serial.sv
// Serial CRC LFSR register: one bit per enabled clock, synchronous clear to
// the preset, asynchronous reset. The combinational next value is exported.
module crc_lfsr_serial
  import crc_pkg::*;
#(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC8_POLY),
  parameter logic [CRC_W-1:0] INIT  = CRC_W'(CRC8_INIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             in_bit,
  output logic [CRC_W-1:0] lfsr,
  output logic [CRC_W-1:0] lfsr_next
);

  logic [CRC_MAX_W-1:0] step_full;

  always_comb begin
    step_full = crc_step(CRC_MAX_W'(lfsr), in_bit, CRC_MAX_W'(POLY), CRC_W);
    lfsr_next = step_full[CRC_W-1:0];
  end

  // Clear wins over enable so a frame can finish and re-arm in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= INIT;
    end else if (clr) begin
      lfsr <= INIT;
    end else if (en) begin
      lfsr <= lfsr_next;
    end
  end

endmodule

// File: rtl/crc_serial_checker.sv
// Receive-side serial CRC checker: rebuilds the message word from an MSB-first
// frame (data then CRC) and flags a non-zero remainder at frame end.
module crc_serial_checker
  import crc_pkg::*;
#(
  parameter int               DATA_BITS = 8,
  parameter int               CRC_W     = 8,
  parameter logic [CRC_W-1:0] POLY      = CRC_W'(CRC8_POLY),
  parameter logic [CRC_W-1:0] INIT      = CRC_W'(CRC8_INIT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 abort,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 crc_err,
  output logic                 busy
);

  localparam int MAX_N = (DATA_BITS > CRC_W) ? DATA_BITS : CRC_W;
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W);

  state_t               state, state_n;
  logic [CNT_W-1:0]     count, count_n, count_inc;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS:0]   shcat;
  logic                 shift_en, lfsr_en, lfsr_clr, done;
  logic [CRC_W-1:0]     lfsr, lfsr_next;

  crc_lfsr_serial #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .INIT  (INIT)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (lfsr_en),
    .clr       (lfsr_clr),
    .in_bit    (in_bit),
    .lfsr      (lfsr),
    .lfsr_next (lfsr_next)
  );

  assign count_inc = count + 1'b1;
  assign shcat     = {shreg, in_bit};
  assign busy      = (state != IDLE);

  always_comb begin
    state_n  = state;
    count_n  = count;
    shift_en = 1'b0;
    lfsr_en  = 1'b0;
    lfsr_clr = 1'b0;
    done     = 1'b0;
    if (abort) begin
      // Abort beats in_valid everywhere, including the final CRC bit.
      state_n  = IDLE;
      count_n  = '0;
      lfsr_clr = 1'b1;
    end else if (in_valid) begin
      lfsr_en = 1'b1;
      case (state)
        IDLE: begin
          shift_en = 1'b1;
          if (DATA_BITS == 1) begin
            state_n = CHECK;
            count_n = '0;
          end else begin
            state_n = DATA;
            count_n = CNT_W'(1);
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (count_inc == DATA_LAST) begin
            state_n = CHECK;
            count_n = '0;
          end else begin
            count_n = count_inc;
          end
        end
        CHECK: begin
          if (count_inc == CRC_LAST) begin
            done     = 1'b1;
            lfsr_clr = 1'b1;
            state_n  = IDLE;
            count_n  = '0;
          end else begin
            count_n = count_inc;
          end
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      data_valid <= done;
      if (shift_en) begin
        shreg <= shcat[DATA_BITS-1:0];
      end
      if (done) begin
        data_out <= shreg;
        crc_err  <= (lfsr_next != '0);
      end
    end
  end

endmodule
